// File: rtl/stk_pkg.sv
// Shared types for the stack pipeline: engine ids, command opcodes and the
// admission-stage busy scoreboard.
package stk_pkg;

    localparam int ENGS_N  = 4;
    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

    typedef logic [ENGID_W-1:0] engid_t;

    typedef enum logic [1:0] {
        OPCODE_NOP  = 2'd0,
        OPCODE_PUSH = 2'd1,
        OPCODE_POP  = 2'd2,
        OPCODE_INV  = 2'd3
    } opcode_t;

    // One busy bit per engine: set on issue, cleared on writeback retire.
    typedef logic [ENGS_N-1:0] adm_busy_t;

    // Successor of idx in a ring of n slots; the wrap is explicit so that
    // non-power-of-two engine counts behave.
    function automatic int ring_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stk_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr and
// moves the pointer one past the winner.
module stk_rr_arb
    import stk_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] scan_idx;
    logic          any_gnt;
    int            scan_int;

    // Scan rr_ptr, rr_ptr+1, ... modulo N and pick the first request.
    always_comb begin
        gnt      = '0;
        any_gnt  = 1'b0;
        ptr_nxt  = rr_ptr;
        scan_int = 0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_int = int'(rr_ptr) + k;
            if (scan_int >= N) begin
                scan_int = scan_int - N;
            end
            scan_idx = PW'(scan_int);
            if (!any_gnt && req[scan_idx]) begin
                gnt[scan_idx] = 1'b1;
                any_gnt       = 1'b1;
                ptr_nxt       = PW'(ring_next(scan_int, N));
            end
        end
    end

    // Advance the pointer past the winner; hold it when nothing is granted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/stk_pipe_adm.sv
// Admission stage of the stack pipeline: round-robin arbitration across
// engines, one outstanding command per engine, push blocking while the
// free-pointer pool is empty, and a registered issue onto the lookup bus.
module stk_pipe_adm
    import stk_pkg::*;
#(
    parameter int ENGS_N = stk_pkg::ENGS_N,
    parameter int DAT_W  = 128
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ENGS_N-1:0] i_cmd_vld,
    input  opcode_t           i_cmd_opcode [ENGS_N],
    input  logic [DAT_W-1:0]  i_cmd_dat    [ENGS_N],
    output logic [ENGS_N-1:0] o_cmd_rdy,
    input  logic              i_alloc_empty,
    input  logic              i_wrbk_uc_vld_r,
    input  engid_t            i_wrbk_uc_engid_r,
    output logic              o_lk_vld_r,
    output engid_t            o_lk_engid_r,
    output opcode_t           o_lk_opcode_r,
    output logic              o_lk_dat_vld_r,
    output logic [DAT_W-1:0]  o_lk_dat_r
);

    logic [ENGS_N-1:0] busy_p0;
    logic [ENGS_N-1:0] retire_hit_p0;
    logic [ENGS_N-1:0] nop_req_p0;
    logic [ENGS_N-1:0] elig_p0;
    logic [ENGS_N-1:0] gnt_p0;
    logic              engid_ok_p0;
    logic              any_gnt_p0;
    engid_t            gnt_idx_p0;
    opcode_t           gnt_op_p0;
    logic [DAT_W-1:0]  gnt_dat_p0;

    // Stage p0: eligibility, with a same-cycle retire bypassing the busy bit.
    always_comb begin
        engid_ok_p0   = int'(i_wrbk_uc_engid_r) < ENGS_N;
        retire_hit_p0 = '0;
        nop_req_p0    = '0;
        elig_p0       = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            retire_hit_p0[i] = i_wrbk_uc_vld_r && engid_ok_p0 &&
                               (i_wrbk_uc_engid_r == ENGID_W'(i));
            nop_req_p0[i]    = i_cmd_vld[i] && (i_cmd_opcode[i] == OPCODE_NOP);
            elig_p0[i]       = i_cmd_vld[i] &&
                               !(busy_p0[i] && !retire_hit_p0[i]) &&
                               !((i_cmd_opcode[i] == OPCODE_PUSH) && i_alloc_empty) &&
                               !nop_req_p0[i];
        end
    end

    stk_rr_arb #(
        .N (ENGS_N)
    ) u_arb (
        .clk    (clk),
        .arst_n (arst_n),
        .req    (elig_p0),
        .gnt    (gnt_p0)
    );

    assign o_cmd_rdy = gnt_p0;

    // Encode the one-hot grant and select the winner's command.
    always_comb begin
        any_gnt_p0 = |gnt_p0;
        gnt_idx_p0 = '0;
        gnt_op_p0  = OPCODE_NOP;
        gnt_dat_p0 = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            if (gnt_p0[i]) begin
                gnt_idx_p0 = ENGID_W'(i);
                gnt_op_p0  = i_cmd_opcode[i];
                gnt_dat_p0 = i_cmd_dat[i];
            end
        end
    end

    // Scoreboard: retire clears, grant sets, set wins on a collision.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_p0 <= '0;
        end else begin
            busy_p0 <= (busy_p0 & ~retire_hit_p0) | gnt_p0;
        end
    end

    // Stage p1: issue register onto the lookup bus; engid and payload hold
    // when idle, payload loads only for pushes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_lk_vld_r     <= 1'b0;
            o_lk_engid_r   <= '0;
            o_lk_opcode_r  <= OPCODE_NOP;
            o_lk_dat_vld_r <= 1'b0;
            o_lk_dat_r     <= '0;
        end else if (any_gnt_p0) begin
            o_lk_vld_r     <= 1'b1;
            o_lk_engid_r   <= gnt_idx_p0;
            o_lk_opcode_r  <= gnt_op_p0;
            o_lk_dat_vld_r <= (gnt_op_p0 == OPCODE_PUSH);
            if (gnt_op_p0 == OPCODE_PUSH) begin
                o_lk_dat_r <= gnt_dat_p0;
            end
        end else begin
            o_lk_vld_r     <= 1'b0;
            o_lk_opcode_r  <= OPCODE_NOP;
            o_lk_dat_vld_r <= 1'b0;
        end
    end

    // Flag illegal upstream behaviour: stray retires, NOP requests, bad engids.
    always @(posedge clk) begin
        if (arst_n) begin
            assert (!(|(retire_hit_p0 & ~busy_p0)))
                else $error("stk_pipe_adm: retire for a non-busy engine");
            assert (!(|nop_req_p0))
                else $error("stk_pipe_adm: NOP opcode requested with vld");
            assert (!(i_wrbk_uc_vld_r && !engid_ok_p0))
                else $error("stk_pipe_adm: retire engid out of range");
        end
    end

endmodule
